// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that owns the J/K inputs of a shared JK flip-flop bank.
// Each accepted command pulses one bit's J/K for a cycle, then returns the sampled Q.
module jk_bank_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [2*NREQ-1:0]          req_op,
    input  logic [IDXW*NREQ-1:0]       req_idx,
    output logic [NREQ-1:0]            req_ready,
    output logic [WIDTH-1:0]           j_out,
    output logic [WIDTH-1:0]           k_out,
    input  logic [WIDTH-1:0]           q_in,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       rsp_q,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    logic [1:0]       state, state_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [1:0]       op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] j_d, k_d;
    logic             rsp_valid_d, rsp_q_d, rsp_err_d;
    logic [IDW-1:0]   rsp_id_d;

    logic             found;
    logic [IDW-1:0]   grant, cand;
    logic [1:0]       gnt_op;
    logic [IDXW-1:0]  gnt_idx;
    logic             gnt_in_range, idx_in_range;

    // Round-robin search starting at ptr, then mux out the winner's command
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        gnt_op  = '0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                gnt_op  = req_op[2*i +: 2];
                gnt_idx = req_idx[IDXW*i +: IDXW];
            end
        end
    end

    assign gnt_in_range = 32'(gnt_idx) < WIDTH;
    assign idx_in_range = 32'(idx_q) < WIDTH;

    // Accept strobe is only offered while idle and never during reset
    assign req_ready = (!rst && (state == ST_IDLE) && found) ? (NREQ'(1) << grant) : '0;

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        op_d        = op_q;
        idx_d       = idx_q;
        id_d        = id_q;
        j_d         = '0;
        k_d         = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_q_d     = rsp_q;
        rsp_err_d   = rsp_err;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    op_d  = gnt_op;
                    idx_d = gnt_idx;
                    id_d  = grant;
                    ptr_d = IDW'((32'(grant) + 32'd1) % NREQ);
                    if (gnt_in_range) begin
                        j_d[gnt_idx] = gnt_op[1];
                        k_d[gnt_idx] = gnt_op[0];
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                rsp_q_d     = idx_in_range ? q_in[idx_q] : 1'b0;
                rsp_err_d   = !idx_in_range;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            id_q      <= '0;
            j_out     <= '0;
            k_out     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            j_out     <= j_d;
            k_out     <= k_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_q     <= rsp_q_d;
            rsp_err   <= rsp_err_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed self-checking bench for jk_bank_scheduler with a behavioural JK bank model.
module tb_jk_bank_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [11:0] req_idx;
    logic [3:0]  req_ready;
    logic [7:0]  j_out, k_out, bank;
    logic        rsp_valid, rsp_q, rsp_err, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid6;
    logic [7:0]  req_op6;
    logic [11:0] req_idx6;
    logic [3:0]  req_ready6;
    logic [5:0]  j6, k6;
    logic [5:0]  q6;
    logic        rsp_valid6, rsp_q6, rsp_err6, busy6;
    logic [1:0]  rsp_id6;

    logic        bank_load;
    logic [7:0]  bank_val;

    int pass_cnt;
    int total_cnt;

    jk_bank_scheduler #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx), .req_ready(req_ready),
        .j_out(j_out), .k_out(k_out), .q_in(bank),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
    );

    jk_bank_scheduler #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut6 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid6), .req_op(req_op6), .req_idx(req_idx6), .req_ready(req_ready6),
        .j_out(j6), .k_out(k6), .q_in(q6),
        .rsp_valid(rsp_valid6), .rsp_id(rsp_id6), .rsp_q(rsp_q6), .rsp_err(rsp_err6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign q6 = 6'b111111;

    // JK bank: Q+ = J & ~Q | ~K & Q, with a bench-side preload
    always_ff @(posedge clk) begin
        if (bank_load) bank <= bank_val;
        else           bank <= (j_out & ~bank) | (~k_out & bank);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] idx);
        req_valid[r]       = 1'b1;
        req_op[2*r +: 2]   = op;
        req_idx[3*r +: 3]  = idx;
    endtask

    task automatic set_req6(input int r, input logic [1:0] op, input logic [2:0] idx);
        req_valid6[r]      = 1'b1;
        req_op6[2*r +: 2]  = op;
        req_idx6[3*r +: 3] = idx;
    endtask

    task automatic preload(input logic [7:0] v);
        bank_load = 1'b1;
        bank_val  = v;
        tick();
        bank_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        bank_load = 1'b1;
        bank_val  = 8'h00;
        req_valid = 4'hF;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got=%h exp=0", req_ready); else pass_cnt++;
        total_cnt++; if ({j_out, k_out} !== 16'h0000) $display("FAIL rst_jk got=%h exp=0", {j_out, k_out}); else pass_cnt++;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_q, rsp_err, busy} !== 6'b0) $display("FAIL rst_rsp got=%b exp=0", {rsp_valid, rsp_id, rsp_q, rsp_err, busy}); else pass_cnt++;
        rst = 1'b0;
        req_valid = 4'h0;
        bank_load = 1'b0;
        tick();
        set_req(2, 2'b10, 3'd3);
        @(negedge clk);
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL rst_pre_ready got=%b exp=0100", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'h0;
        total_cnt++; if (j_out !== 8'h08) $display("FAIL rst_pre_j got=%h exp=08", j_out); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if ({j_out, k_out} !== 16'h0000) $display("FAIL rst_mid_jk got=%h exp=0", {j_out, k_out}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp cyc=%0d got=%b exp=0", c, rsp_valid); else pass_cnt++;
        end
        total_cnt++; if (bank[3] !== 1'b0) $display("FAIL rst_bank3 got=%b exp=0", bank[3]); else pass_cnt++;
        tick();
        for (int r = 0; r < 4; r++) set_req(r, 2'b00, 3'd0);
        @(negedge clk);
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL rst_first_grant got=%b exp=0001", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_single_set();
        preload(8'h00);
        set_req(1, 2'b10, 3'd5);
        @(negedge clk);
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL set_ready got=%b exp=0010", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        total_cnt++; if (j_out !== 8'h20) $display("FAIL set_j got=%h exp=20", j_out); else pass_cnt++;
        total_cnt++; if (k_out !== 8'h00) $display("FAIL set_k got=%h exp=00", k_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL set_busy got=%b exp=1", busy); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if ({j_out, k_out, rsp_valid} !== 17'h0) $display("FAIL set_sample got=%h exp=0", {j_out, k_out, rsp_valid}); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_q, rsp_err} !== 5'b1_01_1_0) $display("FAIL set_rsp got=%b exp=10110", {rsp_valid, rsp_id, rsp_q, rsp_err}); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_q} !== 4'b0_01_1) $display("FAIL set_hold got=%b exp=0011", {rsp_valid, rsp_id, rsp_q}); else pass_cnt++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) set_req(r, 2'b00, 3'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            total_cnt++; if (req_ready !== (4'b0001 << order[s])) $display("FAIL rr_grant slot=%0d got=%b exp=%b", s, req_ready, 4'b0001 << order[s]); else pass_cnt++;
            if (s > 0) begin
                total_cnt++; if ({rsp_valid, rsp_id} !== {1'b1, order[s-1]}) $display("FAIL rr_rsp slot=%0d got=%b exp=%b", s, {rsp_valid, rsp_id}, {1'b1, order[s-1]}); else pass_cnt++;
            end
            tick();
            @(negedge clk);
            total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rr_drive_ready slot=%0d got=%b exp=0", s, req_ready); else pass_cnt++;
            tick();
            @(negedge clk);
            total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rr_sample_ready slot=%0d got=%b exp=0", s, req_ready); else pass_cnt++;
            tick();
        end
        req_valid = 4'h0;
    endtask

    task automatic test_toggle();
        logic [3:0] exp_q;
        exp_q = 4'b0101;
        preload(8'h00);
        set_req(0, 2'b11, 3'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++; if (req_ready !== 4'b0001) $display("FAIL tog_ready it=%0d got=%b exp=0001", i, req_ready); else pass_cnt++;
            if (i > 0) begin
                total_cnt++; if ({rsp_valid, rsp_q} !== {1'b1, exp_q[i-1]}) $display("FAIL tog_rsp it=%0d got=%b exp=%b", i - 1, {rsp_valid, rsp_q}, {1'b1, exp_q[i-1]}); else pass_cnt++;
            end
            tick();
            @(negedge clk);
            total_cnt++; if ({j_out, k_out} !== 16'h0404) $display("FAIL tog_jk it=%0d got=%h exp=0404", i, {j_out, k_out}); else pass_cnt++;
            tick();
            @(negedge clk);
            total_cnt++; if ({j_out, k_out} !== 16'h0000) $display("FAIL tog_jk_off it=%0d got=%h exp=0", i, {j_out, k_out}); else pass_cnt++;
            tick();
        end
        req_valid = 4'h0;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_q} !== {1'b1, exp_q[3]}) $display("FAIL tog_rsp it=3 got=%b exp=%b", {rsp_valid, rsp_q}, {1'b1, exp_q[3]}); else pass_cnt++;
        tick();
    endtask

    task automatic test_hold_reset();
        preload(8'h80);
        set_req(3, 2'b00, 3'd7);
        @(negedge clk);
        total_cnt++; if (req_ready !== 4'b1000) $display("FAIL hold_ready got=%b exp=1000", req_ready); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if ({j_out, k_out} !== 16'h0000) $display("FAIL hold_jk got=%h exp=0", {j_out, k_out}); else pass_cnt++;
        tick();
        tick();
        set_req(3, 2'b01, 3'd7);
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_q} !== 4'b1_11_1) $display("FAIL hold_rsp got=%b exp=1111", {rsp_valid, rsp_id, rsp_q}); else pass_cnt++;
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        total_cnt++; if ({j_out, k_out} !== 16'h0080) $display("FAIL rstop_jk got=%h exp=0080", {j_out, k_out}); else pass_cnt++;
        tick();
        tick();
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_q} !== 4'b1_11_0) $display("FAIL rstop_rsp got=%b exp=1110", {rsp_valid, rsp_id, rsp_q}); else pass_cnt++;
        tick();
    endtask

    task automatic test_error();
        set_req6(2, 2'b11, 3'd7);
        @(negedge clk);
        total_cnt++; if (req_ready6 !== 4'b0100) $display("FAIL err_ready got=%b exp=0100", req_ready6); else pass_cnt++;
        tick();
        req_valid6 = 4'h0;
        @(negedge clk);
        total_cnt++; if ({j6, k6} !== 12'h000) $display("FAIL err_jk got=%h exp=0", {j6, k6}); else pass_cnt++;
        tick();
        tick();
        set_req6(0, 2'b00, 3'd5);
        @(negedge clk);
        total_cnt++; if ({rsp_valid6, rsp_id6, rsp_q6, rsp_err6} !== 5'b1_10_0_1) $display("FAIL err_rsp got=%b exp=11001", {rsp_valid6, rsp_id6, rsp_q6, rsp_err6}); else pass_cnt++;
        total_cnt++; if (req_ready6 !== 4'b0001) $display("FAIL err_next_ready got=%b exp=0001", req_ready6); else pass_cnt++;
        tick();
        req_valid6 = 4'h0;
        tick();
        tick();
        @(negedge clk);
        total_cnt++; if ({rsp_valid6, rsp_id6, rsp_q6, rsp_err6} !== 5'b1_00_1_0) $display("FAIL edge_rsp got=%b exp=10010", {rsp_valid6, rsp_id6, rsp_q6, rsp_err6}); else pass_cnt++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        req_valid  = '0;
        req_op     = '0;
        req_idx    = '0;
        req_valid6 = '0;
        req_op6    = '0;
        req_idx6   = '0;
        bank_load  = 1'b0;
        bank_val   = '0;
        test_reset();
        test_single_set();
        test_round_robin();
        test_toggle();
        test_hold_reset();
        test_error();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
